qpmm_thread_arbiter: RTL and testbench



---
 rtl/qpmm_thread_arbiter.sv | 163 ++++++++++++++++
 tb/tb_qpmm_thread_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpmm_thread_arbiter.sv
// Round-robin arbiter that shares one fixed-latency pipelined Montgomery multiplier
// among N_THREADS requesters, routing each product back through a latency-matched tag pipeline.
module qpmm_thread_arbiter #(
    parameter int N_THREADS = 4,
    parameter int WIDTH     = 289,
    parameter int LAT       = 36,
    parameter int MAX_OUT   = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_THREADS-1:0]           req_valid,
    output logic [N_THREADS-1:0]           req_ready,
    input  logic [N_THREADS*WIDTH-1:0]     req_a,
    input  logic [N_THREADS*WIDTH-1:0]     req_b,
    output logic                           mul_valid,
    output logic [WIDTH-1:0]               mul_a,
    output logic [WIDTH-1:0]               mul_b,
    input  logic                           mul_res_valid,
    input  logic [WIDTH-1:0]               mul_res,
    output logic                           rsp_valid,
    output logic [$clog2(N_THREADS)-1:0]   rsp_tid,
    output logic [WIDTH-1:0]               rsp_data,
    output logic                           err_lat
);

    localparam int TW = $clog2(N_THREADS);
    localparam int CW = $clog2(MAX_OUT) + 1;

    typedef struct packed {
        logic          v;
        logic [TW-1:0] tid;
    } tag_t;

    logic [TW-1:0]        ptr;
    logic [CW-1:0]        cnt      [N_THREADS];
    logic [CW-1:0]        cnt_next [N_THREADS];
    logic [N_THREADS-1:0] eligible;
    logic [N_THREADS-1:0] cnt_inc;
    logic [N_THREADS-1:0] cnt_dec;
    logic                 grant_any;
    logic [TW-1:0]        grant_tid;
    logic [TW-1:0]        issue_tid;
    tag_t                 tag_pipe [LAT];
    tag_t                 tail;

    assign tail = tag_pipe[LAT-1];

    // A thread with MAX_OUT operations in flight is held off until a result returns.
    always_comb begin
        for (int t = 0; t < N_THREADS; t++) begin
            eligible[t] = req_valid[t] && (cnt[t] < CW'(MAX_OUT));
        end
    end

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_tid = '0;
        for (int i = 1; i <= N_THREADS; i++) begin
            if (!grant_any && eligible[ptr + TW'(i)]) begin
                grant_any = 1'b1;
                grant_tid = ptr + TW'(i);
            end
        end
        if (grant_any) begin
            req_ready[grant_tid] = 1'b1;
        end
    end

    // Increment and decrement in the same cycle cancel; a stray decrement at zero
    // (only possible after a latency fault) saturates instead of wrapping.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            cnt_inc[t]  = grant_any && (grant_tid == TW'(t));
            cnt_dec[t]  = rsp_valid && (rsp_tid == TW'(t));
            cnt_next[t] = cnt[t];
            if (cnt_inc[t] && !cnt_dec[t]) begin
                cnt_next[t] = cnt[t] + 1'b1;
            end else if (cnt_dec[t] && !cnt_inc[t] && (cnt[t] != '0)) begin
                cnt_next[t] = cnt[t] - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= TW'(N_THREADS - 1);
            for (int t = 0; t < N_THREADS; t++) begin
                cnt[t] <= '0;
            end
        end else begin
            if (grant_any) begin
                ptr <= grant_tid;
            end
            for (int t = 0; t < N_THREADS; t++) begin
                cnt[t] <= cnt_next[t];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            issue_tid <= '0;
        end else begin
            mul_valid <= grant_any;
            if (grant_any) begin
                mul_a     <= req_a[grant_tid*WIDTH +: WIDTH];
                mul_b     <= req_b[grant_tid*WIDTH +: WIDTH];
                issue_tid <= grant_tid;
            end
        end
    end

    // NOTE: the tag pipeline is reset in full, not left as uninitialised storage,
    // because stale valid bits after reset would be reported as latency faults.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{v: mul_valid, tid: issue_tid};
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // The tail tag and the multiplier output must agree; any disagreement is sticky.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
            err_lat   <= 1'b0;
        end else begin
            rsp_valid <= mul_res_valid;
            if (mul_res_valid) begin
                rsp_tid  <= tail.tid;
                rsp_data <= mul_res;
            end
            if (mul_res_valid != tail.v) begin
                err_lat <= 1'b1;
            end
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));

    for (genvar g = 0; g < N_THREADS; g++) begin : g_cnt_chk
        a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn) cnt[g] <= CW'(MAX_OUT));
    end

endmodule

// File: tb/tb_qpmm_thread_arbiter.sv
// Directed bench for qpmm_thread_arbiter with a behavioural Montgomery multiplier
// (R = 2^WIDTH, BN254 modulus) whose latency can be changed at run time.
module tb_qpmm_thread_arbiter;

    localparam int N   = 4;
    localparam int W   = 289;
    localparam int LAT = 36;
    localparam int MO  = 8;
    localparam logic [2*W+1:0] P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             mul_valid;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_res_valid;
    logic [W-1:0]     mul_res;
    logic             rsp_valid;
    logic [1:0]       rsp_tid;
    logic [W-1:0]     rsp_data;
    logic             err_lat;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int model_lat = LAT;

    logic         mv [64];
    logic [W-1:0] md [64];

    int         rq_cyc  [$];
    logic [1:0] rq_tid  [$];
    logic [W-1:0] rq_data [$];

    qpmm_thread_arbiter #(.N_THREADS(N), .WIDTH(W), .LAT(LAT), .MAX_OUT(MO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_res_valid(mul_res_valid), .mul_res(mul_res),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .err_lat(err_lat)
    );

    always #5 clk = ~clk;

    // Bit-serial Montgomery product a*b*2^-W mod P.
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W+1:0] x, aa, bb;
        aa = {{(W+2){1'b0}}, a};
        bb = {{(W+2){1'b0}}, b};
        x = aa * bb;
        for (int i = 0; i < W; i++) begin
            if (x[0]) x = x + P;
            x = x >> 1;
        end
        if (x >= P) x = x - P;
        return x[W-1:0];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) mv[i] <= 1'b0;
        end else begin
            mv[0] <= mul_valid;
            md[0] <= mul_valid ? mont(mul_a, mul_b) : '0;
            for (int i = 1; i < 64; i++) begin
                mv[i] <= mv[i-1];
                md[i] <= md[i-1];
            end
        end
    end

    assign mul_res_valid = mv[model_lat-1];
    assign mul_res       = md[model_lat-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rstn && rsp_valid) begin
            rq_cyc.push_back(cyc);
            rq_tid.push_back(rsp_tid);
            rq_data.push_back(rsp_data);
        end
    end

    task automatic clear_log();
        rq_cyc.delete();
        rq_tid.delete();
        rq_data.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        req_valid = '0;
        model_lat = LAT;
        repeat (2) @(negedge clk);
        clear_log();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (mul_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mul_valid got %0b want 0", mul_valid); end
        n_cmp++; if (mul_a !== '0 || mul_b !== '0) begin n_bad++; $display("FAIL reset_mul_ops got a=%0h b=%0h want 0", mul_a, mul_b); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_tid !== 2'd0) begin n_bad++; $display("FAIL reset_rsp got v=%0b tid=%0d want 0/0", rsp_valid, rsp_tid); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
        n_cmp++; if (err_lat !== 1'b0) begin n_bad++; $display("FAIL reset_err_lat got %0b want 0", err_lat); end
        req_valid = 4'b1010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL reset_grant got %b want 0010", req_ready); end
        req_valid = '0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_idle_grant got %b want 0000", req_ready); end
    endtask

    task automatic test_round_robin();
        int c0;
        logic [1:0] exp_tid [$];
        logic [W-1:0] exp_data [$];
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) c0 = cyc;
            for (int t = 0; t < N; t++) begin
                req_a[t*W +: W] = W'(100 + 10*t + k/4);
                req_b[t*W +: W] = W'(7 + t);
            end
            req_valid = '1;
            #1;
            n_cmp++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                n_bad++; $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, 4'b0001 << (k % 4));
            end
            exp_tid.push_back(2'(k % 4));
            exp_data.push_back(mont(W'(100 + 10*(k%4) + k/4), W'(7 + k%4)));
        end
        @(negedge clk);
        req_valid = '0;
        for (int t = 0; t < N; t++) begin
            n_cmp++; if (dut.cnt[t] !== 4'd4) begin n_bad++; $display("FAIL rr_cnt_peak t=%0d got %0d want 4", t, dut.cnt[t]); end
        end
        for (int i = 0; i < 80 && rq_cyc.size() < 16; i++) @(negedge clk);
        if (rq_cyc.size() < 16) begin
            n_cmp++; n_bad++; $display("FAIL rr_timeout got %0d responses want 16", rq_cyc.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_cmp++; if (rq_tid[k] !== exp_tid[k]) begin n_bad++; $display("FAIL rr_rsp_tid k=%0d got %0d want %0d", k, rq_tid[k], exp_tid[k]); end
                n_cmp++; if (rq_data[k] !== exp_data[k]) begin n_bad++; $display("FAIL rr_rsp_data k=%0d got %0h want %0h", k, rq_data[k], exp_data[k]); end
                n_cmp++; if (rq_cyc[k] != c0 + k + 38) begin n_bad++; $display("FAIL rr_rsp_cycle k=%0d got %0d want %0d", k, rq_cyc[k] - c0, k + 38); end
            end
        end
        for (int t = 0; t < N; t++) begin
            n_cmp++; if (dut.cnt[t] !== 4'd0) begin n_bad++; $display("FAIL rr_cnt_drained t=%0d got %0d want 0", t, dut.cnt[t]); end
        end
        n_cmp++; if (err_lat !== 1'b0) begin n_bad++; $display("FAIL rr_err_lat got %0b want 0", err_lat); end
    endtask

    task automatic test_single();
        int c;
        apply_reset();
        @(negedge clk);
        req_a[2*W +: W] = W'(3);
        req_b[2*W +: W] = W'(5);
        req_valid = 4'b0100;
        #1;
        c = cyc;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_grant got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_cmp++; if (mul_valid !== 1'b1) begin n_bad++; $display("FAIL single_mul_valid got %0b want 1", mul_valid); end
        n_cmp++; if (mul_a !== W'(3) || mul_b !== W'(5)) begin n_bad++; $display("FAIL single_mul_ops got a=%0h b=%0h want 3/5", mul_a, mul_b); end
        @(negedge clk);
        n_cmp++; if (mul_valid !== 1'b0) begin n_bad++; $display("FAIL single_mul_idle got %0b want 0", mul_valid); end
        for (int i = 0; i < 60 && rq_cyc.size() == 0; i++) @(negedge clk);
        if (rq_cyc.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL single_timeout got 0 responses want 1");
        end else begin
            n_cmp++; if (rq_cyc[0] != c + 38) begin n_bad++; $display("FAIL single_rsp_cycle got %0d want 38", rq_cyc[0] - c); end
            n_cmp++; if (rq_tid[0] !== 2'd2) begin n_bad++; $display("FAIL single_rsp_tid got %0d want 2", rq_tid[0]); end
            n_cmp++; if (rq_data[0] !== mont(W'(3), W'(5))) begin n_bad++; $display("FAIL single_rsp_data got %0h want %0h", rq_data[0], mont(W'(3), W'(5))); end
        end
        n_cmp++; if (err_lat !== 1'b0) begin n_bad++; $display("FAIL single_err_lat got %0b want 0", err_lat); end
    endtask

    task automatic test_credit_limit();
        logic want;
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            req_a[0 +: W] = W'(k + 1);
            req_b[0 +: W] = W'(2);
            req_valid = 4'b0001;
            #1;
            want = (k < 8) || (k >= 39 && k <= 46);
            n_cmp++;
            if (req_ready[0] !== want) begin
                n_bad++; $display("FAIL credit_ready k=%0d got %0b want %0b", k, req_ready[0], want);
            end
        end
        req_valid = '0;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            req_a[W +: W] = W'(k + 20);
            req_b[W +: W] = W'(3);
            req_valid = 4'b0010;
            #1;
            n_cmp++; if (dut.cnt[1] > 4'd8) begin n_bad++; $display("FAIL b2b_cnt_bound k=%0d got %0d want <=8", k, dut.cnt[1]); end
            if (k == 38) begin
                n_cmp++; if (dut.cnt[1] !== 4'd8) begin n_bad++; $display("FAIL b2b_cnt_full got %0d want 8", dut.cnt[1]); end
                n_cmp++; if (req_ready[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_blocked got %0b want 0", req_ready[1]); end
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_tid !== 2'd1) begin n_bad++; $display("FAIL b2b_rsp got v=%0b tid=%0d want 1/1", rsp_valid, rsp_tid); end
            end
            if (k == 39 || k == 40) begin
                n_cmp++; if (dut.cnt[1] !== 4'd7) begin n_bad++; $display("FAIL b2b_cnt_k%0d got %0d want 7", k, dut.cnt[1]); end
                n_cmp++; if (req_ready[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_regrant_k%0d got %0b want 1", k, req_ready[1]); end
            end
        end
        req_valid = '0;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_latency_fault();
        int c;
        apply_reset();
        model_lat = 35;
        @(negedge clk);
        req_a[3*W +: W] = W'(9);
        req_b[3*W +: W] = W'(11);
        req_valid = 4'b1000;
        #1;
        c = cyc;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL lat_grant got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 60 && err_lat !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (err_lat !== 1'b1) begin n_bad++; $display("FAIL lat_err_rise got %0b want 1", err_lat); end
        n_cmp++; if (cyc != c + 37) begin n_bad++; $display("FAIL lat_err_cycle got %0d want 37", cyc - c); end
        repeat (20) @(negedge clk);
        n_cmp++; if (err_lat !== 1'b1) begin n_bad++; $display("FAIL lat_err_sticky got %0b want 1", err_lat); end
        n_cmp++; if (dut.cnt[3] !== 4'd1) begin n_bad++; $display("FAIL lat_cnt3 got %0d want 1", dut.cnt[3]); end
        n_cmp++; if (dut.cnt[0] !== 4'd0) begin n_bad++; $display("FAIL lat_cnt0_saturate got %0d want 0", dut.cnt[0]); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int t = 0; t < N; t++) begin
                req_a[t*W +: W] = W'(50 + t);
                req_b[t*W +: W] = W'(60 + t);
            end
            req_valid = '1;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        n_cmp++; if (mul_a === '0) begin n_bad++; $display("FAIL mid_pre_mul_a got 0 want nonzero"); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (mul_valid !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin n_bad++; $display("FAIL mid_mul got v=%0b a=%0h b=%0h want 0", mul_valid, mul_a, mul_b); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_tid !== 2'd0 || rsp_data !== '0) begin n_bad++; $display("FAIL mid_rsp got v=%0b tid=%0d want 0", rsp_valid, rsp_tid); end
        n_cmp++; if (err_lat !== 1'b0) begin n_bad++; $display("FAIL mid_err_lat got %0b want 0", err_lat); end
        for (int t = 0; t < N; t++) begin
            n_cmp++; if (dut.cnt[t] !== 4'd0) begin n_bad++; $display("FAIL mid_cnt t=%0d got %0d want 0", t, dut.cnt[t]); end
        end
        repeat (2) @(negedge clk);
        clear_log();
        rstn = 1'b1;
        repeat (60) @(negedge clk);
        n_cmp++; if (rq_cyc.size() != 0) begin n_bad++; $display("FAIL mid_no_rsp got %0d responses want 0", rq_cyc.size()); end
        req_valid = 4'b1100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_first_grant got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_credit_limit();
        test_back_to_back();
        test_latency_fault();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
